muldiv_unit: RTL and testbench

- Iterative multiply/divide engine that services the CPU's mult/multu/div/divu requests and owns the architectural HI/LO registers.
- The CPU issues a start request and receives a done pulse; HI/LO also accept direct mthi/mtlo writes.
- hi/lo outputs feed the CPU's mfhi/mflo read mux.
- Radix-2, one bit per cycle: shift-add for multiply, restoring division for divide.

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// CPU-side request/result bundle for the iterative multiply/divide unit.
// The CPU drives the master side; the unit owns HI/LO and the status flags.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative mult/multu/div/divu engine owning the HI/LO registers.
// One bit per cycle on magnitudes; sign fix-up and HI/LO write happen in FIN.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             div_q;
  logic             div0_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [WIDTH-1:0] opnd_q;
  logic [PW-1:0]    prod_q;

  logic             op_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_step;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic [PW-1:0]    div_step;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Operand magnitudes at launch; unsigned ops pass the raw values through.
  always_comb begin
    op_signed = ~bus.op[0];
    a_mag     = bus.rs_val;
    b_mag     = bus.rt_val;
    if (op_signed && bus.rs_val[WIDTH-1]) a_mag = {WIDTH{1'b0}} - bus.rs_val;
    if (op_signed && bus.rt_val[WIDTH-1]) b_mag = {WIDTH{1'b0}} - bus.rt_val;
  end

  // One iteration: shift-add multiply (carry kept) or restoring divide step.
  always_comb begin
    mul_sum  = {1'b0, prod_q[PW-1:WIDTH]} +
               (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_step = {mul_sum, prod_q[WIDTH-1:1]};
    rem_sh   = prod_q[PW-1:WIDTH-1];
    trial    = {1'b0, rem_sh} - {2'b00, opnd_q};
    if (!trial[WIDTH+1])
      div_step = {trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    else
      div_step = {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
  end

  // Final HI/LO values with sign correction and the divide-by-zero override.
  always_comb begin
    res_hi = prod_q[PW-1:WIDTH];
    res_lo = prod_q[WIDTH-1:0];
    if (!div_q) begin
      if (sign_a_q ^ sign_b_q) {res_hi, res_lo} = {PW{1'b0}} - prod_q;
    end else if (div0_q) begin
      res_hi = a_raw_q;
      res_lo = {WIDTH{1'b1}};
    end else begin
      if (sign_a_q ^ sign_b_q) res_lo = {WIDTH{1'b0}} - prod_q[WIDTH-1:0];
      if (sign_a_q)            res_hi = {WIDTH{1'b0}} - prod_q[PW-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      div_q    <= 1'b0;
      div0_q   <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_raw_q  <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            div_q    <= bus.op[1];
            sign_a_q <= op_signed & bus.rs_val[WIDTH-1];
            sign_b_q <= op_signed & bus.rt_val[WIDTH-1];
            a_raw_q  <= bus.rs_val;
            div0_q   <= (bus.rt_val == {WIDTH{1'b0}});
            // Divide iterates on the dividend; multiply shifts out the multiplier.
            if (bus.op[1]) begin
              prod_q <= {{WIDTH{1'b0}}, a_mag};
              opnd_q <= b_mag;
            end else begin
              prod_q <= {{WIDTH{1'b0}}, b_mag};
              opnd_q <= a_mag;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          prod_q <= div_q ? div_step : mul_step;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIN;
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      // The FIN result takes precedence over a same-edge mthi/mtlo.
      if (state_q == FIN) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        if (bus.mthi) hi_q <= bus.wdata;
        if (bus.mtlo) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus
// hand sequences for mid-flight start, mthi collisions and reset abort.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op from a point just after a rising edge and check its result.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input string tag);
    int n;
    bit got;
    bit held;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0; got = 1'b0; held = 1'b1;
    while (!got && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (bus.done) got = 1'b1;
      else if (!bus.busy) held = 1'b0;
    end
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " busy held"}, 64'(held), 64'd1);
    chk({tag, " busy at done"}, 64'(bus.busy), 64'd0);
    chk({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    @(posedge clk);
    #1 chk({tag, " done width"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int ndone;
    errors = 0;
    checks = 0;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[7]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[10] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};

    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.wdata  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);

    // Idle mthi/mtlo write.
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h12345678;
    @(posedge clk);
    #1 bus.mthi = 1'b0; bus.mtlo = 1'b0;
    chk("idle mthi hi", 64'(bus.hi), 64'h12345678);
    chk("idle mtlo lo", 64'(bus.lo), 64'h12345678);
    chk("idle mt busy", 64'(bus.busy), 64'd0);
    chk("idle mt done", 64'(bus.done), 64'd0);

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             $sformatf("vec%0d", i));

    // multu 3*4 with an ignored restart and an mthi while busy.
    bus.op = OP_MULTU; bus.rs_val = 32'd3; bus.rt_val = 32'd4; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin
        bus.start = 1'b1; bus.op = OP_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
      end
      if (k == 6) bus.start = 1'b0;
      if (k == 10) begin bus.mthi = 1'b1; bus.wdata = 32'hDEADBEEF; end
      if (k == 11) bus.mthi = 1'b0;
      @(posedge clk);
      #1;
      if (k == 10) chk("busy mthi hi", 64'(bus.hi), 64'hDEADBEEF);
      if (bus.done) begin
        ndone++;
        chk("restart done edge", 64'(k), 64'd33);
        chk("restart hi", 64'(bus.hi), 64'd0);
        chk("restart lo", 64'(bus.lo), 64'd12);
      end
    end
    chk("restart done count", 64'(ndone), 64'd1);

    // mthi landing on the FIN edge loses to the result.
    bus.op = OP_MULTU; bus.rs_val = 32'd3; bus.rt_val = 32'd4; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (32) @(posedge clk);
    #1 bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hAAAA5555;
    @(posedge clk);
    #1 bus.mthi = 1'b0; bus.mtlo = 1'b0;
    chk("fin collide done", 64'(bus.done), 64'd1);
    chk("fin collide hi", 64'(bus.hi), 64'd0);
    chk("fin collide lo", 64'(bus.lo), 64'd12);

    // Reset mid-mult aborts with no done.
    bus.op = OP_MULT; bus.rs_val = 32'd9; bus.rt_val = 32'd9; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort hi", 64'(bus.hi), 64'd0);
    chk("abort lo", 64'(bus.lo), 64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 if (bus.done) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    run_op(OP_MULT, 32'hFFFFFFFA, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFD6, "post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
